core0_memsys: RTL and testbench

//  Memory-side responder for core0: serves the program memory port (byte read, word write) and the main

---
 rtl/core0_pkg.sv | 27 ++
 rtl/core0_memsys_if.sv | 46 ++++
 rtl/core0_sync_ram.sv | 44 ++++
 rtl/core0_memsys.sv | 138 +++++++++++++
 tb/tb_core0_memsys.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/core0_pkg.sv
// Shared types and size derivations for the core0 memory system.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package core0_pkg;

  // Host load, one priming cycle, then core0 runs
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } memsys_state_t;

  localparam int WORD_MAG_DEF           = 5;
  localparam int PROGRAM_ADDR_WIDTH_DEF = 5;
  localparam int MAIN_ADDR_WIDTH_DEF    = 2;
  localparam int PROG_BYTE_WIDTH        = 8;

  // Number of entries addressed by an address of the given width
  function automatic int pow2(input int width);
    return 1 << width;
  endfunction

  localparam int WORD_WIDTH_DEF   = pow2(WORD_MAG_DEF);
  localparam int PROGRAM_SIZE_DEF = pow2(PROGRAM_ADDR_WIDTH_DEF);
  localparam int MEMORY_SIZE_DEF  = pow2(MAIN_ADDR_WIDTH_DEF);

endpackage

// File: rtl/core0_memsys_if.sv
// Bundle of host-load, program-memory and main-memory signals around core0_memsys.
// Latency: n/a (wiring only).
// Backpressure: load_ready qualifies load_valid; core ports have no backpressure.
interface core0_memsys_if
  import core0_pkg::*;
#(
  parameter int WORD_MAG           = WORD_MAG_DEF,
  parameter int PROGRAM_ADDR_WIDTH = PROGRAM_ADDR_WIDTH_DEF,
  parameter int MAIN_ADDR_WIDTH    = MAIN_ADDR_WIDTH_DEF
) ();

  localparam int WORD_WIDTH = pow2(WORD_MAG);

  logic                          core_reset;
  logic                          load_start;
  logic                          load_valid;
  logic                          load_ready;
  logic [7:0]                    load_data;
  logic                          load_last;
  logic [PROGRAM_ADDR_WIDTH-1:0] programmem_addr;
  logic [7:0]                    programmem_read_value;
  logic [WORD_WIDTH-1:0]         programmem_write_value;
  logic                          programmem_we;
  logic [MAIN_ADDR_WIDTH-1:0]    mainmem_read_addr;
  logic [MAIN_ADDR_WIDTH-1:0]    mainmem_write_addr;
  logic [WORD_WIDTH-1:0]         mainmem_read_value;
  logic [WORD_WIDTH-1:0]         mainmem_write_value;
  logic                          mainmem_we;

  // Host / core side
  modport master (
    input  core_reset, load_ready, programmem_read_value, mainmem_read_value,
    output load_start, load_valid, load_data, load_last,
           programmem_addr, programmem_write_value, programmem_we,
           mainmem_read_addr, mainmem_write_addr, mainmem_write_value, mainmem_we
  );

  // Memory system side
  modport slave (
    output core_reset, load_ready, programmem_read_value, mainmem_read_value,
    input  load_start, load_valid, load_data, load_last,
           programmem_addr, programmem_write_value, programmem_we,
           mainmem_read_addr, mainmem_write_addr, mainmem_write_value, mainmem_we
  );

endinterface

// File: rtl/core0_sync_ram.sv
// Single-write, single-registered-read RAM; optional same-address write forwarding.
// Latency: 1 cycle from read address to rdata; rdata holds when re is low.
// Backpressure: none; writes are blocked while reset is asserted so contents survive reset.
module core0_sync_ram
  import core0_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = pow2(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic                  fwd;

  assign fwd = (BYPASS != 0) && we && (raddr == waddr);

  // Storage array: no reset, only gated off while reset is held
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register: sees the pre-write contents unless forwarding is enabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= fwd ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/core0_memsys.sv
// Memory responder for core0: host program load into program RAM, then core program/main RAM service.
// Latency: 1 cycle for both read ports in RUN; read values hold in LOAD/PRIME. MEMSYS_BYPASS_EN enables main write-forward.
// Backpressure: load_ready high only in LOAD; core ports have no backpressure; load_start in RUN overrides core accesses.
module core0_memsys
  import core0_pkg::*;
#(
  parameter int WORD_MAG           = WORD_MAG_DEF,
  parameter int PROGRAM_ADDR_WIDTH = PROGRAM_ADDR_WIDTH_DEF,
  parameter int MAIN_ADDR_WIDTH    = MAIN_ADDR_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  core0_memsys_if.slave bus
);

  localparam int WORD_WIDTH   = pow2(WORD_MAG);
  localparam int PROGRAM_SIZE = pow2(PROGRAM_ADDR_WIDTH);

`ifdef MEMSYS_BYPASS_EN
  localparam int MAIN_BYPASS = 1;
`else
  localparam int MAIN_BYPASS = 0;
`endif

  memsys_state_t                 state, state_nxt;
  logic [PROGRAM_ADDR_WIDTH-1:0] load_cnt;
  logic                          load_acc;

  logic                          prog_we, prog_re;
  logic [PROGRAM_ADDR_WIDTH-1:0] prog_waddr, prog_raddr;
  logic [7:0]                    prog_wdata, prog_rdata;
  logic                          main_we, main_re;
  logic [WORD_WIDTH-1:0]         main_rdata;

  // Only the low byte of a core program write is stored
  logic unused_prog_hi;
  assign unused_prog_hi = ^bus.programmem_write_value[WORD_WIDTH-1:8];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, handshake outputs and RAM port steering (host owns program write port in LOAD)
  always_comb begin
    state_nxt      = state;
    bus.core_reset = 1'b1;
    bus.load_ready = 1'b0;
    load_acc       = 1'b0;
    prog_we        = 1'b0;
    prog_waddr     = load_cnt;
    prog_wdata     = bus.load_data;
    prog_re        = 1'b0;
    prog_raddr     = bus.programmem_addr;
    main_we        = 1'b0;
    main_re        = 1'b0;
    case (state)
      LOAD: begin
        bus.load_ready = 1'b1;
        load_acc       = bus.load_valid;
        prog_we        = load_acc;
        if (load_acc && (bus.load_last ||
            load_cnt == PROGRAM_ADDR_WIDTH'(PROGRAM_SIZE - 1))) begin
          state_nxt = PRIME;
        end
      end
      PRIME: begin
        // Present byte 0 so core0 sees valid data on its first RUN cycle
        prog_re    = 1'b1;
        prog_raddr = '0;
        state_nxt  = RUN;
      end
      RUN: begin
        bus.core_reset = 1'b0;
        if (bus.load_start) begin
          state_nxt = LOAD;
        end else begin
          prog_re    = 1'b1;
          prog_we    = bus.programmem_we;
          prog_waddr = bus.programmem_addr;
          prog_wdata = bus.programmem_write_value[7:0];
          main_re    = 1'b1;
          main_we    = bus.mainmem_we;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Load byte counter: advances per accepted beat, cleared while priming
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_cnt <= '0;
    end else if (state == PRIME) begin
      load_cnt <= '0;
    end else if (load_acc) begin
      load_cnt <= load_cnt + PROGRAM_ADDR_WIDTH'(1);
    end
  end

  core0_sync_ram #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (PROGRAM_ADDR_WIDTH),
    .BYPASS     (0)
  ) u_prog_ram (
    .clk   (clk),
    .reset (reset),
    .we    (prog_we),
    .waddr (prog_waddr),
    .wdata (prog_wdata),
    .re    (prog_re),
    .raddr (prog_raddr),
    .rdata (prog_rdata)
  );

  core0_sync_ram #(
    .DATA_WIDTH (WORD_WIDTH),
    .ADDR_WIDTH (MAIN_ADDR_WIDTH),
    .BYPASS     (MAIN_BYPASS)
  ) u_main_ram (
    .clk   (clk),
    .reset (reset),
    .we    (main_we),
    .waddr (bus.mainmem_write_addr),
    .wdata (bus.mainmem_write_value),
    .re    (main_re),
    .raddr (bus.mainmem_read_addr),
    .rdata (main_rdata)
  );

  assign bus.programmem_read_value = prog_rdata;
  assign bus.mainmem_read_value    = main_rdata;

endmodule

// File: tb/tb_core0_memsys.sv
// Directed bench for core0_memsys: vector table for load/run traffic, hand sequences for reset and full-image load.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: exercises load_ready gating, load gaps and the no-wrap end of the program image.
module tb_core0_memsys;

`ifdef MEMSYS_BYPASS_EN
  localparam logic [31:0] EXP_FWD = 32'h0000_0005;
`else
  localparam logic [31:0] EXP_FWD = 32'h0000_0000;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  core0_memsys_if #(.WORD_MAG(5), .PROGRAM_ADDR_WIDTH(5), .MAIN_ADDR_WIDTH(2)) bus ();

  core0_memsys #(.WORD_MAG(5), .PROGRAM_ADDR_WIDTH(5), .MAIN_ADDR_WIDTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        lv;
    logic [7:0]  ld;
    logic        ll;
    logic        ls;
    logic [4:0]  pa;
    logic        pwe;
    logic [31:0] pwd;
    logic [1:0]  mra;
    logic [1:0]  mwa;
    logic        mwe;
    logic [31:0] mwd;
    logic        e_cr;
    logic        e_lr;
    logic [7:0]  e_pr;
    logic        cm;
    logic [31:0] e_mr;
  } vec_t;

  localparam int NV = 13;
  vec_t tv [NV];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.load_valid             = v.lv;
    bus.load_data              = v.ld;
    bus.load_last              = v.ll;
    bus.load_start             = v.ls;
    bus.programmem_addr        = v.pa;
    bus.programmem_we          = v.pwe;
    bus.programmem_write_value = v.pwd;
    bus.mainmem_read_addr      = v.mra;
    bus.mainmem_write_addr     = v.mwa;
    bus.mainmem_we             = v.mwe;
    bus.mainmem_write_value    = v.mwd;
  endtask

  task automatic idle();
    vec_t v;
    v = '{0, 8'h00, 0, 0, 5'd0, 0, 32'h0, 2'd0, 2'd0, 0, 32'h0, 0, 0, 8'h00, 0, 32'h0};
    drive(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic cr, input logic lr);
    chk({tag, " core_reset"}, {31'b0, bus.core_reset}, {31'b0, cr});
    chk({tag, " load_ready"}, {31'b0, bus.load_ready}, {31'b0, lr});
  endtask

  initial begin
    //       lv ld     ll ls pa    pwe pwd           mra   mwa   mwe mwd            cr lr pr     cm mr
    tv[0]  = '{1, 8'h01, 0, 0, 5'd0, 0, 32'h0,        2'd0, 2'd0, 0, 32'h0,         1, 1, 8'h00, 1, 32'h0};
    tv[1]  = '{0, 8'h5A, 0, 0, 5'd0, 0, 32'h0,        2'd0, 2'd0, 0, 32'h0,         1, 1, 8'h00, 1, 32'h0};
    tv[2]  = '{1, 8'h02, 0, 0, 5'd0, 0, 32'h0,        2'd0, 2'd0, 0, 32'h0,         1, 1, 8'h00, 1, 32'h0};
    tv[3]  = '{0, 8'h77, 0, 0, 5'd0, 1, 32'h000000FF, 2'd1, 2'd1, 1, 32'h12345678,  1, 1, 8'h00, 1, 32'h0};
    tv[4]  = '{1, 8'h03, 1, 0, 5'd0, 0, 32'h0,        2'd0, 2'd0, 0, 32'h0,         1, 0, 8'h00, 1, 32'h0};
    tv[5]  = '{1, 8'hAA, 0, 0, 5'd2, 0, 32'h0,        2'd0, 2'd0, 0, 32'h0,         0, 0, 8'h01, 1, 32'h0};
    tv[6]  = '{0, 8'h00, 0, 0, 5'd2, 0, 32'h0,        2'd0, 2'd2, 1, 32'h0,         0, 0, 8'h03, 0, 32'h0};
    tv[7]  = '{0, 8'h00, 0, 0, 5'd1, 0, 32'h0,        2'd2, 2'd1, 1, 32'hDEADBEEF,  0, 0, 8'h02, 1, 32'h0};
    tv[8]  = '{0, 8'h00, 0, 0, 5'd0, 1, 32'h00000155, 2'd1, 2'd0, 0, 32'h0,         0, 0, 8'h01, 1, 32'hDEADBEEF};
    tv[9]  = '{0, 8'h00, 0, 0, 5'd0, 0, 32'h0,        2'd2, 2'd2, 1, 32'h5,         0, 0, 8'h55, 1, EXP_FWD};
    tv[10] = '{0, 8'h00, 0, 0, 5'd0, 0, 32'h0,        2'd2, 2'd0, 0, 32'h0,         0, 0, 8'h55, 1, 32'h5};
    tv[11] = '{0, 8'h00, 0, 1, 5'd1, 1, 32'h00000077, 2'd1, 2'd2, 1, 32'h9,         1, 1, 8'h55, 1, 32'h5};
    tv[12] = '{1, 8'h10, 0, 0, 5'd1, 0, 32'h0,        2'd1, 2'd0, 0, 32'h0,         1, 1, 8'h55, 1, 32'h5};

    idle();
    step();
    chk_ctl("reset", 1'b1, 1'b1);
    chk("reset prog_rd", {24'b0, bus.programmem_read_value}, 32'h0);
    chk("reset main_rd", bus.mainmem_read_value, 32'h0);
    reset = 1'b0;

    // Load 01,02,03 with gaps, then run core traffic, then reload via load_start
    for (int i = 0; i < NV; i++) begin
      drive(tv[i]);
      step();
      chk_ctl($sformatf("v%0d", i), tv[i].e_cr, tv[i].e_lr);
      chk($sformatf("v%0d prog_rd", i), {24'b0, bus.programmem_read_value}, {24'b0, tv[i].e_pr});
      if (tv[i].cm) begin
        chk($sformatf("v%0d main_rd", i), bus.mainmem_read_value, tv[i].e_mr);
      end
    end

    // Asynchronous reset in the middle of the reload
    idle();
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h99;
    #3;
    reset = 1'b1;
    #1;
    chk_ctl("async_rst", 1'b1, 1'b1);
    chk("async_rst prog_rd", {24'b0, bus.programmem_read_value}, 32'h0);
    chk("async_rst main_rd", bus.mainmem_read_value, 32'h0);
    bus.load_valid = 1'b0;
    step();
    reset = 1'b0;

    // One-byte image: counter restarted at 0, other bytes retained
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h11;
    bus.load_last  = 1'b1;
    step();
    chk_ctl("short_prime", 1'b1, 1'b0);
    idle();
    bus.programmem_addr   = 5'd1;
    bus.mainmem_read_addr = 2'd2;
    step();
    chk_ctl("short_run", 1'b0, 1'b0);
    chk("short prog0", {24'b0, bus.programmem_read_value}, 32'h11);
    step();
    chk("retained prog1", {24'b0, bus.programmem_read_value}, 32'h02);
    chk("retained main2", bus.mainmem_read_value, 32'h5);

    // Full 32-byte image without load_last
    bus.load_start = 1'b1;
    step();
    chk_ctl("reload", 1'b1, 1'b1);
    bus.load_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 8'h20 + 8'(i);
      step();
      chk_ctl($sformatf("full b%0d", i), 1'b1, (i < 31));
    end
    // 33rd beat in PRIME is refused; load_start there is ignored too
    bus.load_data       = 8'hEE;
    bus.load_start      = 1'b1;
    bus.programmem_addr = 5'd0;
    step();
    chk_ctl("full run", 1'b0, 1'b0);
    chk("full prime prog0", {24'b0, bus.programmem_read_value}, 32'h20);
    idle();
    bus.programmem_addr = 5'd0;
    step();
    chk("full prog0", {24'b0, bus.programmem_read_value}, 32'h20);
    bus.programmem_addr = 5'd31;
    step();
    chk("full prog31", {24'b0, bus.programmem_read_value}, 32'h3F);
    bus.programmem_addr = 5'd1;
    step();
    chk("full prog1", {24'b0, bus.programmem_read_value}, 32'h21);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
